uart_boot_loader: RTL

//  Upstream of the multicycle RV32I core: receives a program image over a UART
//  RX pin (8N1), assembles little-endian 32-bit words and writes them into the

---
 rtl/uart_boot_loader.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_boot_loader.sv
// UART (8N1) program loader: receives a length-prefixed, XOR-checksummed image,
// writes it word by word into memory, and releases the core once it is verified.
module uart_boot_loader #(
    parameter int          CLKS_PER_BIT = 104,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MAX_WORDS    = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rst_n,
    output logic        load_done,
    output logic        load_err
);
    localparam int            CW    = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL  = CW'(CLKS_PER_BIT - 1);
    localparam logic [16:0]   MAX_W = 17'(MAX_WORDS);
    localparam logic [7:0]    MAGIC = 8'hA5;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_t;
    typedef enum logic [2:0] {WAIT_MAGIC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR} state_t;

    rx_state_t   rx_state_q, rx_state_d;
    state_t      state_q, state_d;
    logic        rx_s1_q, rx_s2_q;
    logic [CW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [15:0] len_q, len_d, idx_q, idx_d;
    logic [1:0]  k_q, k_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  xor_q, xor_d;
    logic        mem_we_q, mem_we_d, load_done_q, load_done_d, load_err_q, load_err_d;
    logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic        byte_valid, frame_err;
    logic [15:0] idx_inc, len_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_state_q  <= RX_IDLE;
            state_q     <= WAIT_MAGIC;
            clk_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            k_q         <= '0;
            word_q      <= '0;
            xor_q       <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= BASE_ADDR;
            mem_wdata_q <= '0;
            load_done_q <= 1'b0;
            load_err_q  <= 1'b0;
        end else begin
            rx_s1_q     <= uart_rx;
            rx_s2_q     <= rx_s1_q;
            rx_state_q  <= rx_state_d;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            k_q         <= k_d;
            word_q      <= word_d;
            xor_q       <= xor_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            load_done_q <= load_done_d;
            load_err_q  <= load_err_d;
        end
    end

    // Receiver outputs: decided at the middle of the stop bit.
    always_comb begin
        byte_valid = (rx_state_q == RX_STOP) && (clk_cnt_q == FULL) && rx_s2_q;
        frame_err  = (rx_state_q == RX_STOP) && (clk_cnt_q == FULL) && !rx_s2_q;
    end

    always_comb begin
        rx_state_d = rx_state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        case (rx_state_q)
            RX_IDLE: begin
                if (!rx_s2_q) begin
                    rx_state_d = RX_START;
                    clk_cnt_d  = '0;
                end
            end
            RX_START: begin
                if (clk_cnt_q == HALF) begin
                    clk_cnt_d  = '0;
                    bit_cnt_d  = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == FULL) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s2_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) rx_state_d = RX_STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (clk_cnt_q == FULL) begin
                    clk_cnt_d  = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_WAIT_HIGH;
                end else begin
                    clk_cnt_d = clk_cnt_q + 1'b1;
                end
            end
            RX_WAIT_HIGH: if (rx_s2_q) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign idx_inc = idx_q + 16'd1;
    assign len_n   = {shift_q, len_q[7:0]};

    always_comb begin
        state_d = state_q;
        if (frame_err && (state_q inside {LEN_LO, LEN_HI, DATA, CSUM})) begin
            state_d = ERR;
        end else if (byte_valid) begin
            case (state_q)
                WAIT_MAGIC, ERR: if (shift_q == MAGIC) state_d = LEN_LO;
                LEN_LO: state_d = LEN_HI;
                LEN_HI: begin
                    if ({1'b0, len_n} > MAX_W) state_d = ERR;
                    else if (len_n == 16'd0)   state_d = CSUM;
                    else                       state_d = DATA;
                end
                DATA: if (k_q == 2'd3 && idx_inc == len_q) state_d = CSUM;
                CSUM: state_d = (shift_q == xor_q) ? DONE : ERR;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        len_d       = len_q;
        idx_d       = idx_q;
        k_d         = k_q;
        word_d      = word_q;
        xor_d       = xor_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        load_done_d = load_done_q;
        load_err_d  = load_err_q;
        if (byte_valid) begin
            case (state_q)
                WAIT_MAGIC, ERR: begin
                    if (shift_q == MAGIC) begin
                        xor_d      = '0;
                        idx_d      = '0;
                        k_d        = '0;
                        load_err_d = 1'b0;
                    end
                end
                LEN_LO: begin
                    len_d[7:0] = shift_q;
                    xor_d      = xor_q ^ shift_q;
                end
                LEN_HI: begin
                    len_d[15:8] = shift_q;
                    xor_d       = xor_q ^ shift_q;
                    k_d         = '0;
                end
                DATA: begin
                    word_d[8*k_q +: 8] = shift_q;
                    xor_d              = xor_q ^ shift_q;
                    k_d                = k_q + 2'd1;
                    if (k_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = BASE_ADDR + {14'd0, idx_q, 2'b00};
                        mem_wdata_d = {shift_q, word_q[23:0]};
                        idx_d       = idx_inc;
                    end
                end
                default: ;
            endcase
        end
        if (state_d == ERR)  load_err_d  = 1'b1;
        if (state_d == DONE) load_done_d = 1'b1;
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign load_done = load_done_q;
    assign load_err  = load_err_q;
    assign cpu_rst_n = load_done_q;
endmodule
